// File: rtl/spi_accel_if.sv
// SPI pins shared between an SPI master and the accelerometer register slave.
interface spi_accel_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_accel_slave.sv
// SPI mode-0 register slave for an accelerometer: ID registers, per-transaction
// axis snapshot, and one writable POWER_CTL register, all sampled in the clk domain.
module spi_accel_slave #(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_accel_if.slave        spi,
  input  logic signed [11:0] x_data,
  input  logic signed [11:0] y_data,
  input  logic signed [11:0] z_data,
  output logic [7:0]        power_ctl,
  output logic              meas_mode,
  output logic              wr_strobe,
  output logic [5:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int unsigned AXIS_W = 12;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h0A;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;
  localparam logic [ADDR_W-1:0] ADDR_PWR  = 6'h2D;

  logic [1:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        cs_sync_q, cs_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_in_q, shift_in_d;
  logic [BYTE_W-1:0] shift_out_q, shift_out_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [AXIS_W-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_z_q, snap_z_d;
  logic [BYTE_W-1:0] power_ctl_q, power_ctl_d;
  logic              meas_mode_q, meas_mode_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              miso_q, miso_d;
  logic              busy_q, busy_d;

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall, cs_fall, byte_done;
  logic [BYTE_W-1:0] rx_byte, rd_byte;
  logic [ADDR_W-1:0] rd_addr;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // A cs fall only counts once cs has been seen high after reset, so a reset
  // released mid-transaction waits for the next genuine transaction start.
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign rx_byte   = {shift_in_q[BYTE_W-2:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], spi.sclk};
    cs_sync_d   = {cs_sync_q[0], spi.cs};
    mosi_sync_d = {mosi_sync_q[0], spi.mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    settle_d    = {settle_q[0], 1'b1};
    armed_d     = armed_q | (settle_q[1] & cs_s);
  end

  // Read mux: during ADDR the byte just received is the first address to fetch.
  assign rd_addr = (state_q == ST_ADDR) ? rx_byte[ADDR_W-1:0] : ADDR_W'(ptr_q + 6'd1);

  always_comb begin
    rd_byte = '0;
    case (rd_addr)
      6'h00:   rd_byte = DEVID_AD;
      6'h01:   rd_byte = DEVID_MST;
      6'h02:   rd_byte = PARTID;
      6'h0E:   rd_byte = snap_x_q[7:0];
      6'h0F:   rd_byte = {{4{snap_x_q[11]}}, snap_x_q[11:8]};
      6'h10:   rd_byte = snap_y_q[7:0];
      6'h11:   rd_byte = {{4{snap_y_q[11]}}, snap_y_q[11:8]};
      6'h12:   rd_byte = snap_z_q[7:0];
      6'h13:   rd_byte = {{4{snap_z_q[11]}}, snap_z_q[11:8]};
      ADDR_PWR: rd_byte = power_ctl_q;
      default: rd_byte = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    is_read_d   = is_read_q;
    ptr_d       = ptr_q;
    snap_x_d    = snap_x_q;
    snap_y_d    = snap_y_q;
    snap_z_d    = snap_z_q;
    power_ctl_d = power_ctl_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    miso_d      = miso_q;

    if (cs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      if (sclk_rise && (state_q != ST_IDLE)) begin
        shift_in_d = rx_byte;
        bit_cnt_d  = CNT_W'(bit_cnt_q + 3'd1);
      end
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            snap_x_d  = AXIS_W'(x_data);
            snap_y_d  = AXIS_W'(y_data);
            snap_z_d  = AXIS_W'(z_data);
          end
        end
        ST_CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_WRITE) begin
              state_d   = ST_ADDR;
              is_read_d = 1'b0;
            end else if (rx_byte == CMD_READ) begin
              state_d   = ST_ADDR;
              is_read_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (byte_done) begin
            ptr_d = rx_byte[ADDR_W-1:0];
            if (is_read_q) begin
              state_d     = ST_RDATA;
              shift_out_d = rd_byte;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (byte_done) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
            wr_data_d   = rx_byte;
            if (ptr_q == ADDR_PWR) power_ctl_d = rx_byte;
            ptr_d = ADDR_W'(ptr_q + 6'd1);
          end
        end
        ST_RDATA: begin
          if (byte_done) begin
            ptr_d       = ADDR_W'(ptr_q + 6'd1);
            shift_out_d = rd_byte;
          end else if (sclk_fall) begin
            miso_d      = shift_out_q[BYTE_W-1];
            shift_out_d = {shift_out_q[BYTE_W-2:0], 1'b0};
          end
        end
        ST_IGNORE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    meas_mode_d = (power_ctl_d[1:0] == 2'b10);
    busy_d      = ~cs_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      is_read_q   <= 1'b0;
      ptr_q       <= '0;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      snap_z_q    <= '0;
      power_ctl_q <= '0;
      meas_mode_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      is_read_q   <= is_read_d;
      ptr_q       <= ptr_d;
      snap_x_q    <= snap_x_d;
      snap_y_q    <= snap_y_d;
      snap_z_q    <= snap_z_d;
      power_ctl_q <= power_ctl_d;
      meas_mode_q <= meas_mode_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

  assign spi.miso  = miso_q;
  assign power_ctl = power_ctl_q;
  assign meas_mode = meas_mode_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_accel_slave.sv
// Bench for spi_accel_slave: directed register-map scenarios plus randomized
// transactions checked against a register-level model of the device.
module tb_spi_accel_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_accel_if spi_if ();
  logic signed [11:0] x_data, y_data, z_data;
  logic [7:0] power_ctl;
  logic       meas_mode, wr_strobe, busy;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  spi_accel_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_if),
    .x_data    (x_data),
    .y_data    (y_data),
    .z_data    (z_data),
    .power_ctl (power_ctl),
    .meas_mode (meas_mode),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every strobe seen on the bus, as {addr, data}.
  logic [13:0] wr_log[$];
  always @(negedge clk) if (wr_strobe === 1'b1) wr_log.push_back({wr_addr, wr_data});

  // Device model: register contents as the master should see them.
  logic [7:0]  m_pwr;
  logic [11:0] m_x, m_y, m_z;

  function automatic logic [7:0] axis_byte(input logic [11:0] v, input bit hi);
    int iv;
    iv = int'(signed'(v));
    return hi ? 8'((iv >>> 8) & 255) : 8'(iv & 255);
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    if (a == 6'h00) return 8'hAD;
    if (a == 6'h01) return 8'h1D;
    if (a == 6'h02) return 8'hF2;
    if (a == 6'h0E || a == 6'h0F) return axis_byte(m_x, a[0]);
    if (a == 6'h10 || a == 6'h11) return axis_byte(m_y, a[0]);
    if (a == 6'h12 || a == 6'h13) return axis_byte(m_z, a[0]);
    if (a == 6'h2D) return m_pwr;
    return 8'h00;
  endfunction

  logic [7:0] tx_buf[8];
  logic [7:0] rx_buf[8];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of tx MSB first at SCLK = clk/8; miso captured just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_if.mosi = tx[i];
      wait_clk(4);
      rx[i] = spi_if.miso;
      spi_if.sclk = 1'b1;
      wait_clk(4);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_if.cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    spi_if.cs = 1'b1;
    wait_clk(6);
  endtask

  // Full-byte transaction; optionally disturbs axis inputs after the snapshot point.
  task automatic run_txn(input int n, input bit scramble);
    wr_log.delete();
    m_x = x_data; m_y = y_data; m_z = z_data;
    cs_low();
    check_eq("busy_active", 32'(busy), 32'd1);
    if (scramble) begin
      x_data = 12'($urandom); y_data = 12'($urandom); z_data = 12'($urandom);
    end
    for (int k = 0; k < n; k++) spi_bits(tx_buf[k], 8, rx_buf[k]);
    cs_high();
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_read(input logic [5:0] a, input int nb, input bit scramble);
    tx_buf[0] = 8'h0B;
    tx_buf[1] = {2'($urandom), a};
    for (int k = 0; k < nb; k++) tx_buf[2+k] = 8'($urandom);
    run_txn(nb + 2, scramble);
    check_eq("rd_cmd_miso", 32'(rx_buf[0]), 32'd0);
    check_eq("rd_addr_miso", 32'(rx_buf[1]), 32'd0);
    for (int k = 0; k < nb; k++)
      check_eq($sformatf("rd_data_a%0h", 6'(a + 6'(k))), 32'(rx_buf[2+k]), 32'(m_read(6'(a + 6'(k)))));
    check_eq("rd_no_strobe", 32'(wr_log.size()), 32'd0);
  endtask

  // Data bytes are taken from tx_buf[2..] as prepared by the caller.
  task automatic do_write(input logic [5:0] a, input int nb, input bit scramble);
    tx_buf[0] = 8'h0A;
    tx_buf[1] = {2'($urandom), a};
    run_txn(nb + 2, scramble);
    check_eq("wr_strobe_cnt", 32'(wr_log.size()), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      logic [5:0] wa;
      wa = 6'(a + 6'(k));
      if (k < wr_log.size())
        check_eq($sformatf("wr_entry_%0d", k), 32'(wr_log[k]), 32'({wa, tx_buf[2+k]}));
      if (wa == 6'h2D) m_pwr = tx_buf[2+k];
    end
    for (int k = 0; k < nb + 2; k++) check_eq("wr_miso", 32'(rx_buf[k]), 32'd0);
    check_eq("wr_power_ctl", 32'(power_ctl), 32'(m_pwr));
    check_eq("wr_meas_mode", 32'(meas_mode), 32'(m_pwr[1:0] == 2'b10));
  endtask

  task automatic do_ignore(input logic [7:0] cmd, input int nb);
    tx_buf[0] = cmd;
    for (int k = 1; k <= nb; k++) tx_buf[k] = 8'($urandom);
    run_txn(nb + 1, 1'b1);
    for (int k = 0; k <= nb; k++) check_eq("ign_miso", 32'(rx_buf[k]), 32'd0);
    check_eq("ign_no_strobe", 32'(wr_log.size()), 32'd0);
    check_eq("ign_power_ctl", 32'(power_ctl), 32'(m_pwr));
  endtask

  initial begin
    logic [7:0] rx;
    rst_n = 1'b0;
    spi_if.cs = 1'b1; spi_if.sclk = 1'b0; spi_if.mosi = 1'b0;
    x_data = '0; y_data = '0; z_data = '0;
    m_pwr = 8'h00;
    wait_clk(3);
    check_eq("rst_power_ctl", 32'(power_ctl), 32'h00);
    check_eq("rst_meas_mode", 32'(meas_mode), 32'd0);
    check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_miso", 32'(spi_if.miso), 32'd0);
    rst_n = 1'b1;
    wait_clk(6);

    // Enable measurement mode via POWER_CTL.
    tx_buf[2] = 8'h02;
    do_write(6'h2D, 1, 1'b0);
    check_eq("pwr_write_addr", 32'(wr_addr), 32'h2D);
    check_eq("pwr_write_data", 32'(wr_data), 32'h02);
    check_eq("pwr_write_value", 32'(power_ctl), 32'h02);
    check_eq("pwr_meas_mode", 32'(meas_mode), 32'd1);

    // Negative X sample read as low then sign-extended high byte.
    x_data = 12'hF85;
    do_read(6'h0E, 2, 1'b0);
    check_eq("x_low", 32'(rx_buf[2]), 32'h85);
    check_eq("x_high", 32'(rx_buf[3]), 32'hFF);

    // Burst read across the 0x3F -> 0x00 pointer wrap.
    do_read(6'h3F, 3, 1'b1);
    check_eq("wrap_3f", 32'(rx_buf[2]), 32'h00);
    check_eq("wrap_00", 32'(rx_buf[3]), 32'hAD);
    check_eq("wrap_01", 32'(rx_buf[4]), 32'h1D);

    do_ignore(8'h55, 2);

    // Chip select released after half a data byte: nothing is written.
    wr_log.delete();
    cs_low();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'hFF, 4, rx);
    cs_high();
    check_eq("partial_no_strobe", 32'(wr_log.size()), 32'd0);
    check_eq("partial_power_ctl", 32'(power_ctl), 32'h02);

    // Writes to read-only space are strobed but change nothing.
    tx_buf[2] = 8'h5A; tx_buf[3] = 8'hC3;
    do_write(6'h00, 2, 1'b1);
    tx_buf[2] = 8'h03;
    do_write(6'h2D, 1, 1'b0);

    // Reset asserted mid-read, released while cs is still low.
    wr_log.delete();
    cs_low();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h00, 4, rx);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_miso", 32'(spi_if.miso), 32'd0);
    check_eq("midrst_power_ctl", 32'(power_ctl), 32'h00);
    check_eq("midrst_meas_mode", 32'(meas_mode), 32'd0);
    m_pwr = 8'h00;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h77, 8, rx);
    cs_high();
    check_eq("postrst_no_strobe", 32'(wr_log.size()), 32'd0);
    check_eq("postrst_power_ctl", 32'(power_ctl), 32'h00);
    do_read(6'h02, 1, 1'b0);
    check_eq("postrst_partid", 32'(rx_buf[2]), 32'hF2);

    // Randomized mix of reads, writes and unknown commands.
    for (int t = 0; t < 40; t++) begin
      int op;
      logic [5:0] a;
      logic [7:0] cmd;
      x_data = 12'($urandom); y_data = 12'($urandom); z_data = 12'($urandom);
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        a = ($urandom_range(0, 1) == 1) ? 6'(6'h2D - 6'($urandom_range(0, 2))) : 6'($urandom);
        for (int k = 0; k < 3; k++) tx_buf[2+k] = 8'($urandom);
        do_write(a, int'($urandom_range(1, 3)), 1'b1);
      end else if (op == 1) begin
        case ($urandom_range(0, 3))
          0: a = 6'h0E;
          1: a = 6'($urandom_range(6'h0E, 6'h13));
          2: a = 6'($urandom_range(6'h3D, 6'h3F));
          default: a = 6'($urandom);
        endcase
        do_read(a, int'($urandom_range(1, 4)), 1'b1);
      end else begin
        do cmd = 8'($urandom); while (cmd == 8'h0A || cmd == 8'h0B);
        do_ignore(cmd, int'($urandom_range(1, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
